// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: field widths,
// the last legal opcode, FSM state encoding and an opcode legality helper.
package alu_seq_pkg;

    localparam int OPC_W   = 4;
    localparam int OPND_W  = 3;
    localparam int RES_W   = 6;
    localparam int ENTRY_W = OPC_W + 2 * OPND_W;

    localparam logic [OPC_W-1:0] OPC_LAST = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // True for opcodes the ALU defines (0 .. OPC_LAST).
    function automatic logic opc_legal(input logic [OPC_W-1:0] opc);
        return opc <= OPC_LAST;
    endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Operation FIFO for the ALU sequencer. Power-of-two depth so the
// pointers wrap naturally; storage is not reset, only pointers and count.
module alu_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign do_push = push && (count_reg != FULL_COUNT);
    assign do_pop  = pop && (count_reg != '0);

    // Storage write; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointer and occupancy tracking; push+pop together leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rdata = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: queues operations, issues them one at a time
// to an external registered ALU, waits ALU_LAT clocks and captures the
// result into a single valid/ready output slot.
// Optional feature macro: ALU_SEQ_OPCODE_CHECK_EN (drop illegal opcodes
// and pulse err_illegal).
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_opa,
    input  logic [OPND_W-1:0] in_opb,
    input  logic [OPC_W-1:0]  in_opcode,
    output logic [OPND_W-1:0] alu_opa,
    output logic [OPND_W-1:0] alu_opb,
    output logic [OPC_W-1:0]  alu_opcode,
    input  logic [RES_W-1:0]  alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_result,
    output logic [OPC_W-1:0]  out_opcode,
    output logic              busy,
    output logic              err_illegal
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);
    localparam logic [AW:0]      FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                rst_done_reg;
    logic                accept;
    logic                fifo_push;
    logic                fifo_pop;
    logic                capture;
    logic [AW:0]         fifo_count;
    logic [ENTRY_W-1:0]  fifo_wdata;
    logic [ENTRY_W-1:0]  fifo_rdata;
    logic [OPND_W-1:0]   alu_opa_reg, alu_opb_reg;
    logic [OPC_W-1:0]    alu_opcode_reg;
    logic                out_valid_reg;
    logic [RES_W-1:0]    out_result_reg;
    logic [OPC_W-1:0]    out_opcode_reg;

    // in_ready stays low until the first clock after reset release.
    assign in_ready   = rst_done_reg && (fifo_count < FULL_COUNT);
    assign accept     = in_valid && in_ready;
    assign fifo_wdata = {in_opcode, in_opa, in_opb};

`ifdef ALU_SEQ_OPCODE_CHECK_EN
    logic err_illegal_reg;

    assign fifo_push = accept && opc_legal(in_opcode);

    // One-cycle flag for a handshake whose opcode was dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_illegal_reg <= 1'b0;
        end else begin
            err_illegal_reg <= accept && !opc_legal(in_opcode);
        end
    end

    assign err_illegal = err_illegal_reg;
`else
    assign fifo_push   = accept;
    assign err_illegal = 1'b0;
`endif

    alu_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    // Next-state logic: pop in IDLE, one ISSUE cycle, then count down the ALU latency.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        fifo_pop   = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (fifo_count != '0) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_next   = CNT_W'(ALU_LAT);
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_reg > CNT_ONE) begin
                    cnt_next = cnt_reg - CNT_ONE;
                end else if (!out_valid_reg || out_ready) begin
                    capture    = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // FSM state, wait counter and reset-release flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            rst_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            rst_done_reg <= 1'b1;
        end
    end

    // ALU operand registers load only on a pop and otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opa_reg    <= '0;
            alu_opb_reg    <= '0;
            alu_opcode_reg <= '0;
        end else if (fifo_pop) begin
            {alu_opcode_reg, alu_opa_reg, alu_opb_reg} <= fifo_rdata;
        end
    end

    // Output slot: capture has priority; a lone out_ready drains it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
            out_opcode_reg <= '0;
        end else if (capture) begin
            out_valid_reg  <= 1'b1;
            out_result_reg <= alu_result;
            out_opcode_reg <= alu_opcode_reg;
        end else if (out_ready) begin
            out_valid_reg  <= 1'b0;
        end
    end

    assign alu_opa    = alu_opa_reg;
    assign alu_opb    = alu_opb_reg;
    assign alu_opcode = alu_opcode_reg;
    assign out_valid  = out_valid_reg;
    assign out_result = out_result_reg;
    assign out_opcode = out_opcode_reg;
    assign busy       = (state_reg != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: external ALU model, directed scenarios
// and a randomized run, all checked by a queue-based scoreboard.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 1;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_opa, in_opb;
    logic [3:0] in_opcode;
    logic [2:0] alu_opa, alu_opb;
    logic [3:0] alu_opcode;
    logic [5:0] alu_result;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_result;
    logic [3:0] out_opcode;
    logic       busy;
    logic       err_illegal;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_cyc;
    logic rand_rdy = 1'b0;

    typedef struct packed {
        logic [3:0] op;
        logic [5:0] res;
    } exp_t;

    exp_t       exp_q[$];
    int         out_cyc_q[$];
    logic [5:0] out_res_q[$];

    alu_op_sequencer #(
        .DEPTH   (DEPTH),
        .ALU_LAT (ALU_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opa      (in_opa),
        .in_opb      (in_opb),
        .in_opcode   (in_opcode),
        .alu_opa     (alu_opa),
        .alu_opb     (alu_opb),
        .alu_opcode  (alu_opcode),
        .alu_result  (alu_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_opcode  (out_opcode),
        .busy        (busy),
        .err_illegal (err_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behaviour of the downstream ALU attached in the examples (6-bit results).
    function automatic logic [5:0] alu_f(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b);
        logic [5:0] x, y;
        x = {3'b000, a};
        y = {3'b000, b};
        case (op)
            4'h0: return x + y;
            4'h1: return x - y;
            4'h2: return x * y;
            4'h3: return x & y;
            4'h4: return x | y;
            4'h5: return x ^ y;
            4'h6: return ~(x & y);
            4'h7: return ~(x ^ y);
            4'h8: return x << b;
            4'h9: return y - x;
            4'hA: return x;
            4'hB: return y;
            default: return {a, b};
        endcase
    endfunction

    // ALU with ALU_LAT register stages.
    logic [5:0] alu_pipe [ALU_LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= alu_f(alu_opcode, alu_opa, alu_opb);
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_result = alu_pipe[ALU_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // Scoreboard producer: every accepted handshake yields an expected result.
    logic err_exp = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                err_exp = 1'b0;
            end else begin
                chk("err_illegal", err_illegal, err_exp);
                err_exp = 1'b0;
                if (in_valid && in_ready) begin
`ifdef ALU_SEQ_OPCODE_CHECK_EN
                    if (in_opcode > OPC_LAST) err_exp = 1'b1;
                    else
`endif
                    exp_q.push_back({in_opcode, alu_f(in_opcode, in_opa, in_opb)});
                end
            end
        end
    end

    // Monitor: compares each delivered result and checks hold under backpressure.
    logic       hold_prev = 1'b0;
    logic [5:0] prev_res;
    logic [3:0] prev_op;
    exp_t       mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_result", out_result, prev_res);
                    chk("hold_opcode", out_opcode, prev_op);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_output", $sformatf("got result %0d opcode %0d, expected none", out_result, out_opcode));
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("out_result", out_result, mon_e.res);
                        chk("out_opcode", out_opcode, mon_e.op);
                        $display("out: result=%0d opcode=%0d cycle=%0d", out_result, out_opcode, cyc);
                    end
                    out_cyc_q.push_back(cyc);
                    out_res_q.push_back(out_result);
                end
                hold_prev = out_valid && !out_ready;
                prev_res  = out_result;
                prev_op   = out_opcode;
            end
        end
    end

    // Random downstream readiness during the randomized phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Present one operation, wait (bounded) for acceptance; returns 1 ns after the edge.
    task automatic push(input logic [2:0] a, input logic [2:0] b, input logic [3:0] op);
        int n;
        in_opa    = a;
        in_opb    = b;
        in_opcode = op;
        in_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("push_timeout", "in_ready never asserted, expected 1");
        else acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) until every expected result was delivered and the DUT is idle.
    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_left"}, exp_q.size(), 0);
        chk({name, "_busy"}, busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_result"}, out_result, 0);
        chk({tag, "_out_opcode"}, out_opcode, 0);
        chk({tag, "_alu_opa"}, alu_opa, 0);
        chk({tag, "_alu_opb"}, alu_opb, 0);
        chk({tag, "_alu_opcode"}, alu_opcode, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err_illegal, 0);
    endtask

    initial begin
        int n;
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_opa    = '0;
        in_opb    = '0;
        in_opcode = '0;
        out_ready = 1'b0;

        // Reset values, then release.
        #12;
        check_reset_vals("init");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_release", in_ready, 1);
        chk("busy_after_release", busy, 0);
        @(posedge clk);
        #1;

        // Single operation: result and latency from acceptance.
        out_ready = 1'b1;
        push(3'd3, 3'd4, 4'h0);
        @(negedge clk);
        chk("busy_after_push", busy, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("single_latency", cyc - acc_cyc, ALU_LAT + 3);
        chk("single_result", out_result, 7);
        chk("single_opcode", out_opcode, 0);
        drain("single");

        // Back-to-back operations: order, values and spacing.
        out_cyc_q.delete();
        out_res_q.delete();
        push(3'd5, 3'd4, 4'h2);
        push(3'd3, 3'd6, 4'h7);
        n = 0;
        while (out_cyc_q.size() < 2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (out_cyc_q.size() < 2) begin
            fail_now("b2b_count", $sformatf("got %0d results, expected 2", out_cyc_q.size()));
        end else begin
            chk("b2b_spacing", out_cyc_q[1] - out_cyc_q[0], ALU_LAT + 2);
            chk("b2b_first", out_res_q[0], 20);
            chk("b2b_second", out_res_q[1], 58);
        end
        drain("b2b");

        // Backpressure: capacity is output slot + in-flight op + DEPTH entries.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) push(3'($urandom), 3'($urandom), 4'($urandom_range(0, 11)));
        repeat (6) @(negedge clk);
        chk("bp_full_ready", in_ready, 0);
        chk("bp_full_busy", busy, 1);
        @(posedge clk);
        #1;
        in_opa = 3'd1; in_opb = 3'd2; in_opcode = 4'h0; in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("bp_no_accept", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("bp");

        // Push and pop on the same edge with DEPTH-1 entries queued.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push(3'($urandom), 3'($urandom), 4'($urandom_range(0, 11)));
        repeat (6) @(negedge clk);
        chk("pp_ready_before", in_ready, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        push(3'd2, 3'd5, 4'h4);
        @(negedge clk);
        chk("pp_ready_after", in_ready, 1);
        @(posedge clk);
        #1;
        drain("pp");

        // Illegal opcode followed by a legal one.
        out_res_q.delete();
        push(3'd0, 3'd0, 4'hC);
        push(3'd3, 3'd3, 4'h9);
        drain("illegal");
`ifdef ALU_SEQ_OPCODE_CHECK_EN
        chk("illegal_count", out_res_q.size(), 1);
`else
        chk("illegal_count", out_res_q.size(), 2);
`endif
        if (out_res_q.size() > 0) chk("illegal_last", out_res_q[out_res_q.size()-1], 0);

        // Reset while one op waits and two are queued.
        out_ready = 1'b1;
        push(3'd1, 3'd1, 4'h0);
        push(3'd2, 3'd2, 4'h0);
        push(3'd3, 3'd1, 4'h0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_output", seen, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            push(3'($urandom), 3'($urandom), 4'($urandom_range(0, 15)));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
